// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// It detects load-use hazards, generates the PC and IF/ID stall/flush controls, and keeps saturating debug counters.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [6:0]       id_op,
    input  logic             id_regwrite,
    input  logic             id_memwrite,
    input  logic [4:0]       id_aluop,
    input  logic [2:0]       id_npcop,
    input  logic             id_alusrc,
    input  logic [1:0]       id_wdsel,
    input  logic [2:0]       id_dmtype,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memwrite,
    output logic [4:0]       ex_aluop,
    output logic [2:0]       ex_npcop,
    output logic             ex_alusrc,
    output logic [1:0]       ex_wdsel,
    output logic [2:0]       ex_dmtype,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic [4:0]      aluop;
        logic [2:0]      npcop;
        logic            alusrc;
        logic [1:0]      wdsel;
        logic [2:0]      dmtype;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_bundle_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_bundle_t       ex_q, ex_d, id_bundle_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             rs1_used_s, rs2_used_s, lu_hazard_s;
    logic             stall_inc_s, flush_inc_s;

    // Decode which source registers the ID instruction actually reads
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        case (id_op)
            7'b0110111, 7'b0010111, 7'b1101111: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            default: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    // A load in EX whose rd is a live source of the ID instruction forces one bubble
    always_comb begin
        lu_hazard_s = ex_q.valid & (ex_q.wdsel == 2'b01) & (ex_q.rd != 5'd0) & id_valid &
                      ((rs1_used_s & (id_rs1 == ex_q.rd)) | (rs2_used_s & (id_rs2 == ex_q.rd)));
        stall_inc_s = lu_hazard_s & ~ex_redirect & ~ex_hold;
        flush_inc_s = ex_redirect & ~ex_hold;
    end

    // Pack the ID-side inputs into the same layout as the EX register
    always_comb begin
        id_bundle_s = '{valid: id_valid, regwrite: id_regwrite, memwrite: id_memwrite,
                        aluop: id_aluop, npcop: id_npcop, alusrc: id_alusrc,
                        wdsel: id_wdsel, dmtype: id_dmtype, pc: id_pc,
                        rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                        rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    end

    // EX register next state: hold beats redirect, which beats the load-use bubble
    always_comb begin
        ex_d = ex_q;
        if (ex_hold) begin
            ex_d = ex_q;
        end else if (ex_redirect | lu_hazard_s) begin
            ex_d = '0;
        end else begin
            ex_d = id_bundle_s;
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_inc_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_aluop    = ex_q.aluop;
    assign ex_npcop    = ex_q.npcop;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_wdsel    = ex_q.wdsel;
    assign ex_dmtype   = ex_q.dmtype;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;

    assign pc_stall    = ex_hold | (lu_hazard_s & ~ex_redirect);
    assign if_id_stall = ex_hold | (lu_hazard_s & ~ex_redirect);
    assign if_id_flush = flush_inc_s;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/redirect/reset cases plus random traffic
// against a behavioural pipeline model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic [4:0]  aluop;
        logic [2:0]  npcop;
        logic        alusrc;
        logic [1:0]  wdsel;
        logic [2:0]  dmtype;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bun_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic id_valid = 1'b0, id_regwrite = 1'b0, id_memwrite = 1'b0, id_alusrc = 1'b0;
    logic [6:0] id_op = 7'd0;
    logic [4:0] id_aluop = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic [2:0] id_npcop = 3'd0, id_dmtype = 3'd0;
    logic [1:0] id_wdsel = 2'd0;
    logic [31:0] id_pc = 32'd0, id_rs1_data = 32'd0, id_rs2_data = 32'd0, id_imm = 32'd0;
    logic ex_redirect = 1'b0, ex_hold = 1'b0;

    logic ex_valid, ex_regwrite, ex_memwrite, ex_alusrc;
    logic [4:0] ex_aluop, ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_npcop, ex_dmtype;
    logic [1:0] ex_wdsel;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic pc_stall, if_id_stall, if_id_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_op(id_op),
        .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_aluop(id_aluop),
        .id_npcop(id_npcop), .id_alusrc(id_alusrc), .id_wdsel(id_wdsel),
        .id_dmtype(id_dmtype), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
        .ex_aluop(ex_aluop), .ex_npcop(ex_npcop), .ex_alusrc(ex_alusrc),
        .ex_wdsel(ex_wdsel), .ex_dmtype(ex_dmtype), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    bun_t m_ex;
    int   m_scnt, m_fcnt;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bun_t cur_in();
        return '{valid: id_valid, regwrite: id_regwrite, memwrite: id_memwrite, aluop: id_aluop,
                 npcop: id_npcop, alusrc: id_alusrc, wdsel: id_wdsel, dmtype: id_dmtype,
                 pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                 rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    endfunction

    function automatic bun_t dut_ex();
        return '{valid: ex_valid, regwrite: ex_regwrite, memwrite: ex_memwrite, aluop: ex_aluop,
                 npcop: ex_npcop, alusrc: ex_alusrc, wdsel: ex_wdsel, dmtype: ex_dmtype,
                 pc: ex_pc, rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm,
                 rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd};
    endfunction

    // Model: does the instruction in ID read a register the load in EX has not yet produced?
    function automatic bit model_hazard(input bun_t id, input logic [6:0] op);
        bit reads1, reads2;
        reads1 = !(op inside {OP_LUI, OP_AUI, OP_JAL});
        reads2 = (op inside {OP_R, OP_S, OP_B});
        if (!(m_ex.valid && m_ex.wdsel == 2'b01 && m_ex.rd != 5'd0 && id.valid)) return 1'b0;
        return (reads1 && id.rs1 == m_ex.rd) || (reads2 && id.rs2 == m_ex.rd);
    endfunction

    // One clock: check the combinational controls, advance the model, then check the EX state.
    task automatic step();
        bun_t cur;
        bit   hz;
        #1;
        cur = cur_in();
        hz  = model_hazard(cur, id_op);
        chk("pc_stall", 192'(pc_stall), 192'(ex_hold | (hz & ~ex_redirect)));
        chk("if_id_stall", 192'(if_id_stall), 192'(ex_hold | (hz & ~ex_redirect)));
        chk("if_id_flush", 192'(if_id_flush), 192'(ex_redirect & ~ex_hold));
        if (!ex_hold) begin
            if (hz && !ex_redirect && m_scnt < CMAX) m_scnt++;
            if (ex_redirect && m_fcnt < CMAX) m_fcnt++;
            if (ex_redirect || hz) m_ex = '0;
            else m_ex = cur;
        end
        @(posedge clk);
        @(negedge clk);
        chk("ex_bundle", 192'(dut_ex()), 192'(m_ex));
        chk("stall_cnt", 192'(stall_cnt), 192'(m_scnt));
        chk("flush_cnt", 192'(flush_cnt), 192'(m_fcnt));
    endtask

    task automatic set_in(input logic v, input logic [6:0] op, input logic [1:0] wd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic redir, input logic hold);
        id_valid = v; id_op = op; id_wdsel = wd; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_imm = imm; ex_redirect = redir; ex_hold = hold;
        id_regwrite = 1'($urandom); id_memwrite = 1'($urandom); id_aluop = 5'($urandom);
        id_npcop = 3'($urandom); id_alusrc = 1'($urandom); id_dmtype = 3'($urandom);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    endtask

    // Assert reset between clock edges and check it takes effect without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_ex_valid", 192'(ex_valid), 192'(0));
        chk("rst_ex_regwrite", 192'(ex_regwrite), 192'(0));
        chk("rst_bundle", 192'(dut_ex()), 192'(0));
        chk("rst_stall_cnt", 192'(stall_cnt), 192'(0));
        chk("rst_flush_cnt", 192'(flush_cnt), 192'(0));
        m_ex = '0; m_scnt = 0; m_fcnt = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{OP_LOAD, OP_I, OP_R, OP_S, OP_B, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
        m_ex = '0; m_scnt = 0; m_fcnt = 0;
        #12;
        do_reset();

        // addi x5,x1,3 passes straight through
        set_in(1'b1, OP_I, 2'b00, 5'd1, 5'd0, 5'd5, 32'd3, 1'b0, 1'b0);
        step();
        chk("addi_rd", 192'(ex_rd), 192'(5));
        chk("addi_imm", 192'(ex_imm), 192'(3));
        chk("addi_valid", 192'(ex_valid), 192'(1));

        // lw x5 then add x6,x5,x2: one bubble, then add enters EX
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_R, 2'b00, 5'd5, 5'd2, 5'd6, 32'd0, 1'b0, 1'b0);
        #1 chk("lu_pc_stall", 192'(pc_stall), 192'(1));
        step();
        chk("lu_bubble", 192'(ex_valid), 192'(0));
        chk("lu_stall_cnt", 192'(stall_cnt), 192'(1));
        step();
        chk("lu_add_rd", 192'(ex_rd), 192'(6));
        chk("lu_add_valid", 192'(ex_valid), 192'(1));

        // lw x0 followed by a user of x0
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_R, 2'b00, 5'd0, 5'd0, 5'd7, 32'd0, 1'b0, 1'b0);
        step();
        chk("x0_no_stall", 192'(ex_valid), 192'(1));
        // lw x5 followed by lui x5 (rs1 field also 5)
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_LUI, 2'b00, 5'd5, 5'd5, 5'd5, 32'h1000, 1'b0, 1'b0);
        step();
        chk("lui_no_stall", 192'(ex_valid), 192'(1));
        // lw x5 followed by addi with rs2 field 5
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_I, 2'b00, 5'd3, 5'd5, 5'd8, 32'd9, 1'b0, 1'b0);
        step();
        chk("rs2_unused_no_stall", 192'(ex_valid), 192'(1));
        chk("no_stall_cnt", 192'(stall_cnt), 192'(1));

        // Redirect together with a load-use hazard
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_R, 2'b00, 5'd5, 5'd2, 5'd6, 32'd0, 1'b1, 1'b0);
        #1;
        chk("redir_flush", 192'(if_id_flush), 192'(1));
        chk("redir_pc_stall", 192'(pc_stall), 192'(0));
        step();
        chk("redir_bubble", 192'(ex_valid), 192'(0));
        chk("redir_flush_cnt", 192'(flush_cnt), 192'(1));

        // Same situation with hold: EX keeps the load
        set_in(1'b1, OP_LOAD, 2'b01, 5'd1, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, OP_R, 2'b00, 5'd5, 5'd2, 5'd6, 32'd0, 1'b1, 1'b1);
        #1;
        chk("hold_flush", 192'(if_id_flush), 192'(0));
        chk("hold_stall", 192'(if_id_stall), 192'(1));
        step();
        chk("hold_rd", 192'(ex_rd), 192'(5));
        chk("hold_valid", 192'(ex_valid), 192'(1));

        // Reset mid-stall, then the first edge is a normal update
        set_in(1'b1, OP_R, 2'b00, 5'd5, 5'd2, 5'd6, 32'd0, 1'b0, 1'b0);
        do_reset();
        set_in(1'b1, OP_I, 2'b00, 5'd1, 5'd0, 5'd9, 32'd4, 1'b0, 1'b0);
        step();
        chk("post_rst_rd", 192'(ex_rd), 192'(9));

        // Flush counter saturation
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, OP_I, 2'b00, 5'd1, 5'd0, 5'd2, 32'd0, 1'b1, 1'b0);
            step();
        end
        chk("flush_sat", 192'(flush_cnt), 192'(15));

        // Random traffic biased toward loads and small register indices
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 8)],
                   ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
